// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM behind a req/gnt/valid port with a fixed
// response latency, optional periodic grant throttling, and an error flag for out-of-range accesses.
module dmem_responder #(
  parameter int          MEM_DEPTH    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          RESP_LATENCY = 1,
  parameter int          STALL_EVERY  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_gnt,
  output logic [31:0] data_rdata,
  output logic        data_valid,
  output logic        data_error
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (STALL_EVERY > 1) ? $clog2(STALL_EVERY) : 1;

  logic        stall_cycle;
  logic        accept;
  logic        hit;
  logic [30:0] offset;
  logic [AW-1:0] idx;
  logic        unused_lsb;

  logic [31:0] mem [MEM_DEPTH];

  logic [RESP_LATENCY-1:0] pipe_vld;
  logic [RESP_LATENCY-1:0] pipe_err;
  logic [31:0]             pipe_dat [RESP_LATENCY];

  generate
    if (STALL_EVERY >= 2) begin : g_stall
      logic [CW-1:0] stall_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stall_cnt <= '0;
        end else if (stall_cnt == CW'(STALL_EVERY - 1)) begin
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end

      assign stall_cycle = (stall_cnt == CW'(STALL_EVERY - 1));
    end else begin : g_no_stall
      assign stall_cycle = 1'b0;
    end
  endgenerate

  assign data_gnt = data_req & ~stall_cycle & ~reset;
  assign accept   = data_req & data_gnt;

  // Word-granular offset; a borrow (address below base) lands in the high bits and reads as a miss.
  assign offset     = {1'b0, data_addr[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign hit        = (offset[30:AW] == '0);
  assign idx        = offset[AW-1:0];
  assign unused_lsb = ^data_addr[1:0];

  always_ff @(posedge clk) begin
    if (accept && data_wr && hit) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be[i]) begin
          mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= accept;
      pipe_err[0] <= accept & ~hit;
      if (accept) begin
        pipe_dat[0] <= (data_wr || !hit) ? 32'h0 : mem[idx];
      end
      // Data only moves with a valid entry so the output word holds while idle.
      for (int i = 1; i < RESP_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_err[i] <= pipe_err[i-1];
        if (pipe_vld[i-1]) begin
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign data_valid = pipe_vld[RESP_LATENCY-1];
  assign data_error = pipe_err[RESP_LATENCY-1];
  assign data_rdata = pipe_dat[RESP_LATENCY-1];

endmodule

// File: tb/tb_dmem_responder.sv
// Three responder instances (latency 1, latency 3, latency 2 with stall period 4) checked every
// cycle against a transaction-level memory model, plus directed literal expectations.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam longint MBASE = 0;
  localparam longint MSPAN = 4 * 4096;

  logic        clk = 1'b0;
  logic        rst   [NI];
  logic        req   [NI];
  logic        wr    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  be    [NI];
  logic        gnt   [NI];
  logic [31:0] rdata [NI];
  logic        valid [NI];
  logic        err   [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .MEM_DEPTH   (4096),
      .BASE_ADDR   (32'h0),
      .RESP_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 2)),
      .STALL_EVERY ((g == 2) ? 4 : 0)
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .data_req  (req[g]),
      .data_wr   (wr[g]),
      .data_addr (addr[g]),
      .data_wdata(wdata[g]),
      .data_be   (be[g]),
      .data_gnt  (gnt[g]),
      .data_rdata(rdata[g]),
      .data_valid(valid[g]),
      .data_error(err[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
  endfunction

  function automatic int stl_of(input int g);
    return (g == 2) ? 4 : 0;
  endfunction

  // Model state: memory image, per-cycle accept history, response log.
  logic [31:0] mm [NI][4096];
  bit          mk [NI][4096];
  int          kc [NI];
  int          lastg [NI];
  bit          hv [NI][16];
  bit          he [NI][16];
  bit          hk [NI][16];
  logic [31:0] hd [NI][16];
  logic [31:0] rlog_d [NI][64];
  bit          rlog_e [NI][64];
  int          rlog_c [NI][64];
  int          rcnt [NI];
  bit          glog [64];

  initial begin
    for (int g = 0; g < NI; g++) begin
      kc[g] = 0;
      rcnt[g] = 0;
      lastg[g] = -1;
      for (int w = 0; w < 4096; w++) mk[g][w] = 1'b0;
    end
  end

  always @(negedge clk) begin
    int k, lat, stl, slot, ps, w;
    bit eg, ev, hit;
    for (int g = 0; g < NI; g++) begin
      if (rst[g]) begin
        chk("rst_valid", 32'(valid[g]), 32'h0);
        chk("rst_gnt", 32'(gnt[g]), 32'h0);
        chk("rst_error", 32'(err[g]), 32'h0);
        chk("rst_rdata", rdata[g], 32'h0);
        kc[g] = 0;
        for (int s = 0; s < 16; s++) hv[g][s] = 1'b0;
      end else begin
        k   = kc[g];
        lat = lat_of(g);
        stl = stl_of(g);
        eg  = req[g] && !(stl >= 2 && (k % stl) == stl - 1);
        chk("gnt", 32'(gnt[g]), 32'(eg));
        if (g == 2 && k < 64) glog[k] = gnt[g];
        ev = (k >= lat) && hv[g][(k - lat) % 16];
        chk("valid", 32'(valid[g]), 32'(ev));
        if (ev) begin
          ps = (k - lat) % 16;
          chk("error", 32'(err[g]), 32'(he[g][ps]));
          if (hk[g][ps]) chk("rdata", rdata[g], hd[g][ps]);
          if (rcnt[g] < 64) begin
            rlog_d[g][rcnt[g]] = rdata[g];
            rlog_e[g][rcnt[g]] = err[g];
            rlog_c[g][rcnt[g]] = k;
          end
          rcnt[g]++;
        end else begin
          chk("error_idle", 32'(err[g]), 32'h0);
        end
        slot = k % 16;
        hv[g][slot] = 1'b0;
        if (req[g] && eg) begin
          lastg[g] = k;
          hit = (longint'(addr[g]) >= MBASE) && (longint'(addr[g]) < MBASE + MSPAN);
          w   = hit ? int'((longint'(addr[g]) - MBASE) >> 2) : 0;
          hv[g][slot] = 1'b1;
          he[g][slot] = !hit;
          if (wr[g]) begin
            hd[g][slot] = 32'h0;
            hk[g][slot] = 1'b1;
            if (hit) begin
              for (int i = 0; i < 4; i++)
                if (be[g][i]) mm[g][w][8*i +: 8] = wdata[g][8*i +: 8];
              if (be[g] == 4'hF) mk[g][w] = 1'b1;
            end
          end else begin
            hd[g][slot] = hit ? mm[g][w] : 32'h0;
            hk[g][slot] = hit ? mk[g][w] : 1'b1;
          end
        end
        kc[g] = k + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request and holds it until granted; returns the grant cycle index.
  task automatic xfer(input int g, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int gk);
    bit done;
    req[g] = 1'b1; wr[g] = w; addr[g] = a; wdata[g] = d; be[g] = b;
    done = 1'b0;
    gk = -1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (gnt[g]) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (done) gk = lastg[g];
    else begin
      chk("gnt_timeout", 32'h0, 32'h1);
      req[g] = 1'b0;
    end
  endtask

  task automatic idle(input int g);
    req[g] = 1'b0; wr[g] = 1'b0; addr[g] = 32'h0; wdata[g] = 32'h0; be[g] = 4'h0;
  endtask

  initial begin
    int g0, g1, r0;
    for (int g = 0; g < NI; g++) begin
      rst[g] = 1'b1;
      idle(g);
    end
    tick(3);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick(2);

    // Write then read the same word, latency 1.
    r0 = rcnt[0];
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, g0);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, g1);
    idle(0);
    tick(4);
    chk("t1_b2b_grant", 32'(g1), 32'(g0 + 1));
    chk("t1_wr_cycle", 32'(rlog_c[0][r0]), 32'(g0 + 1));
    chk("t1_wr_err", 32'(rlog_e[0][r0]), 32'h0);
    chk("t1_wr_data", rlog_d[0][r0], 32'h0);
    chk("t1_rd_cycle", 32'(rlog_c[0][r0+1]), 32'(g0 + 2));
    chk("t1_rd_data", rlog_d[0][r0+1], 32'hDEADBEEF);

    // Byte-enabled merge.
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, g0);
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, g0);
    xfer(0, 0, 32'h20, 32'h0, 4'h0, g0);
    idle(0);
    tick(3);
    chk("t2_merge", rlog_d[0][rcnt[0]-1], 32'h11BB33DD);

    // Out-of-range accesses must not alias onto word 0.
    xfer(0, 1, 32'h0, 32'h01020304, 4'hF, g0);
    r0 = rcnt[0];
    xfer(0, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, g0);
    xfer(0, 0, 32'h4000, 32'h0, 4'h0, g0);
    xfer(0, 0, 32'h0, 32'h0, 4'h0, g0);
    idle(0);
    tick(3);
    chk("t3_wmiss_err", 32'(rlog_e[0][r0+1]), 32'h1);
    chk("t3_wmiss_data", rlog_d[0][r0+1], 32'h0);
    chk("t3_rmiss_err", 32'(rlog_e[0][r0+2]), 32'h1);
    chk("t3_rmiss_data", rlog_d[0][r0+2], 32'h0);
    chk("t3_w0_err", 32'(rlog_e[0][r0+3]), 32'h0);
    chk("t3_w0_data", rlog_d[0][r0+3], 32'h01020304);

    // Latency 3, four reads back to back.
    for (int i = 0; i < 4; i++) xfer(1, 1, 32'h100 + 32'(4*i), 32'hC0DE0000 + 32'(i), 4'hF, g0);
    idle(1);
    tick(5);
    r0 = rcnt[1];
    xfer(1, 0, 32'h100, 32'h0, 4'h0, g0);
    for (int i = 1; i < 4; i++) xfer(1, 0, 32'h100 + 32'(4*i), 32'h0, 4'h0, g1);
    idle(1);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      chk("t4_cycle", 32'(rlog_c[1][r0+i]), 32'(g0 + 3 + i));
      chk("t4_data", rlog_d[1][r0+i], 32'hC0DE0000 + 32'(i));
    end

    // Stall every 4th cycle while req is held for 12 cycles.
    r0 = rcnt[2];
    rst[2] = 1'b0;
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h12345678; be[2] = 4'hF;
    tick(12);
    idle(2);
    tick(4);
    for (int k = 0; k < 12; k++) chk("t5_gnt_pattern", 32'(glog[k]), 32'((k % 4) != 3));
    chk("t5_resp_count", 32'(rcnt[2] - r0), 32'd9);

    // Reset with two responses in flight.
    xfer(1, 1, 32'h8, 32'h5A5A5A5A, 4'hF, g0);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, g0);
    idle(1);
    r0 = rcnt[1];
    rst[1] = 1'b1;
    tick(2);
    rst[1] = 1'b0;
    tick(6);
    chk("t6_dropped", 32'(rcnt[1] - r0), 32'h0);
    xfer(1, 0, 32'h8, 32'h0, 4'h0, g0);
    idle(1);
    tick(5);
    chk("t6_persist", rlog_d[1][rcnt[1]-1], 32'h5A5A5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Synthesizable responder (slave) end of the core data-memory req/gnt/valid interface.
- Accepts read and write requests from riscv_core.
- Stores data in an internal word-addressed RAM.
- Returns one in-order response per granted request after a fixed, parameterized latency.
- Replaces the behavioural data side of the bench memory; usable in FPGA builds.

Parameters:
- MEM_DEPTH, 4096, RAM size in 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_DEPTH.
- RESP_LATENCY, 1, cycles from grant cycle to data_valid; legal range 1..8.
- STALL_EVERY, 0, grant throttle period; 0 = never stall, N>=2 = data_gnt forced low one cycle in every N.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_req  input  1  request valid from core.
- data_wr  input  1  1 = write, 0 = read; qualified by data_req.
- data_addr  input  32  byte address; bits [1:0] ignored.
- data_wdata  input  32  write data, lane-aligned.
- data_be  input  4  byte enables; bit i enables byte lane i.
- data_gnt  output  1  request accepted this cycle.
- data_rdata  output  32  read data, valid with data_valid.
- data_valid  output  1  one-cycle response strobe.
- data_error  output  1  response error flag, valid with data_valid.

Behaviour:
- Reset values:
  - data_gnt=0 while reset is high.
  - data_valid=0, data_rdata=0, data_error=0, asynchronously.
  - Stall counter=0.
  - Response pipeline cleared.
  - RAM contents are not reset.
- Grant:
  - data_gnt = data_req & ~stall_cycle. Combinational from data_req.
  - A transaction is accepted in any cycle with data_req & data_gnt.
  - Back-to-back acceptance, one per cycle, is allowed.
- Stall:
  - Counter runs 0..STALL_EVERY-1 every cycle out of reset and wraps to 0.
  - stall_cycle = (STALL_EVERY>=2) & (count==STALL_EVERY-1).
  - The core holds req/addr/wdata/be stable until granted; no internal capture happens on stalled cycles.
- Address check:
  - hit = (data_addr >= BASE_ADDR) & (data_addr < BASE_ADDR+4*MEM_DEPTH).
  - Word index = (data_addr-BASE_ADDR)[log2(MEM_DEPTH)+1:2].
- Write:
  - On the accept edge, if hit, RAM[idx] byte lane i <= data_wdata[8i+7:8i] for each data_be[i]=1.
  - be=4'b0000 is a legal no-op write.
  - Response: rdata=0, error=~hit. A miss never modifies the RAM.
- Read:
  - RAM[idx] is sampled at the accept edge, so a read accepted the cycle after a write to the same word returns the new data.
  - Full word is returned regardless of data_be.
  - Miss: rdata=0, error=1.
- Response pipeline:
  - Shift register of RESP_LATENCY stages; each stage holds {valid, rdata, error}.
  - Stage 0 loads at the accept edge; the last stage drives the outputs (registered).
  - data_valid is high exactly in cycle G+RESP_LATENCY for a transaction granted in cycle G.
  - Responses stay in grant order; up to RESP_LATENCY transactions are in flight.
  - No response backpressure exists; every granted request produces exactly one data_valid pulse.
- Idle: data_valid=0 and data_error=0. data_rdata holds its last value; it is don't-care when valid is low.
- Reset mid-operation: all in-flight responses are dropped and no valid is emitted for them. Writes already committed at the accept edge persist.
- Simultaneous accept and a response emerging: both happen in the same cycle (pipeline shift).
- Unknown data_wr/addr while data_req=0: ignored.

Test Plan:
1. Write then read, RESP_LATENCY=1:
   - Stimulus: write addr 0x10, wdata 0xDEADBEEF, be 4'hF, granted cycle G; read 0x10 granted G+1.
   - Required: valid at G+1 with error=0, rdata=0; valid at G+2 with rdata=0xDEADBEEF.
2. Byte enables:
   - Stimulus: preload 0x11223344 at 0x20; write wdata 0xAABBCCDD, be 4'b0101; read 0x20.
   - Required: rdata=0x11BB33DD.
3. Out of range, MEM_DEPTH=4096, BASE_ADDR=0:
   - Stimulus: write 0x4000 with 0xFFFFFFFF; read 0x4000; read 0x0.
   - Required: first two responses error=1 and rdata=0; RAM unchanged; read 0x0 has error=0.
4. Latency and back-to-back, RESP_LATENCY=3:
   - Stimulus: 4 reads granted in consecutive cycles G..G+3.
   - Required: valid high G+3..G+6, rdata in request order, no gaps.
5. Stall, STALL_EVERY=4:
   - Stimulus: req held high continuously for 12 cycles.
   - Required: data_gnt low on cycles 3, 7, 11 after reset release, high otherwise; exactly 9 responses.
6. Reset mid-flight, RESP_LATENCY=3:
   - Stimulus: grant write 0x8 = 0x5A5A5A5A and read 0x8; assert reset one cycle later.
   - Required: no data_valid during or after reset for those requests; a subsequent read of 0x8 returns 0x5A5A5A5A.
